// File: rtl/dmem_access.sv
// Data-memory access stage: one load/store at a time over a valid/ready request + response bus.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse misalign_trap.
module dmem_access #(
  parameter int ADDR_W       = 32,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              wb_load_active,
  output logic [4:0]        wb_next_rd,
  output logic [31:0]       wb_next_rd_value,
  output logic              bus_err,
  output logic              misalign_trap
);
  // state | meaning
  // IDLE  | waiting for a load/store from execute
  // REQ   | request on the bus until accepted
  // RESP  | waiting for response, timeout timer running
  // DONE  | one-cycle result/ack slot, pipeline released
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RESP_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [4:0]        rd_q;
  logic              is_load_q;
  logic              load_active_q;
  logic [4:0]        next_rd_q;
  logic [31:0]       next_val_q;
  logic              bus_err_q;

  logic        accept, misalign, load_done, timeout, in_req, store_req;
  logic [1:0]  off;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val, st_wdata;
  logic [3:0]  st_wstrb;

  assign accept = ex_valid & (ex_is_load | ex_is_store);
  assign off    = addr_q[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic trap_q;
  assign misalign = (ex_funct3[1:0] == 2'b01) ? ex_addr[0] :
                    (ex_funct3[1] ? (ex_addr[1:0] != 2'b00) : 1'b0);
  always_ff @(posedge clk) begin
    if (rst) trap_q <= 1'b0;
    else     trap_q <= (state_q == IDLE) & accept & misalign;
  end
  assign misalign_trap = trap_q;
`else
  assign misalign      = 1'b0;
  assign misalign_trap = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    stall     = 1'b0;
    load_done = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          state_d = RESP;
          timer_d = TIMER_LOAD;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          load_done = is_load_q;
          state_d   = DONE;
        end else if (timer_q == '0) begin
          timeout = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // funct3[1:0]: 00 byte, 01 half, anything else word; funct3[2] selects zero-extension
  always_comb begin
    rbyte    = mem_resp_rdata[{off, 3'b000} +: 8];
    rhalf    = mem_resp_rdata[{off[1], 4'b0000} +: 16];
    load_val = mem_resp_rdata;
    st_wstrb = 4'hF;
    st_wdata = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        load_val = {{24{~funct3_q[2] & rbyte[7]}}, rbyte};
        st_wstrb = 4'b0001 << off;
        st_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        load_val = {{16{~funct3_q[2] & rhalf[15]}}, rhalf};
        st_wstrb = 4'b0011 << {off[1], 1'b0};
        st_wdata = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      funct3_q      <= '0;
      addr_q        <= '0;
      sdata_q       <= '0;
      rd_q          <= '0;
      is_load_q     <= 1'b0;
      load_active_q <= 1'b0;
      next_rd_q     <= '0;
      next_val_q    <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      load_active_q <= load_done & (rd_q != 5'd0);
      bus_err_q     <= timeout;
      if (state_q == IDLE && accept) begin
        funct3_q  <= ex_funct3;
        addr_q    <= ex_addr;
        sdata_q   <= ex_store_data;
        rd_q      <= ex_rd;
        is_load_q <= ex_is_load;
      end
      if (load_done) begin
        next_rd_q  <= rd_q;
        next_val_q <= load_val;
      end
    end
  end

  assign in_req    = (state_q == REQ);
  assign store_req = in_req & ~is_load_q;

  assign mem_req_valid    = in_req;
  assign mem_req_we       = store_req;
  assign mem_req_addr     = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wdata    = store_req ? st_wdata : '0;
  assign mem_req_wstrb    = store_req ? st_wstrb : '0;
  assign wb_load_active   = load_active_q;
  assign wb_next_rd       = next_rd_q;
  assign wb_next_rd_value = next_val_q;
  assign bus_err          = bus_err_q;
endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed scenarios plus randomized accesses
// checked against a lane/extension reference model.
module tb_dmem_access;
  localparam int RT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        stall, mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        wb_load_active;
  logic [4:0]  wb_next_rd;
  logic [31:0] wb_next_rd_value;
  logic        bus_err, misalign_trap;

  int checks = 0;
  int errors = 0;

  int          obs_stall_bad, obs_req_cyc, obs_unstable, obs_t0_req, obs_berr_early;
  logic        obs_after, obs_we, obs_la, obs_berr, obs_trap, obs_done_stall;
  logic [31:0] obs_addr, obs_wdata, obs_val;
  logic [3:0]  obs_wstrb;
  logic [4:0]  obs_rd;

  dmem_access #(.ADDR_W(32), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_load_active(wb_load_active), .wb_next_rd(wb_next_rd), .wb_next_rd_value(wb_next_rd_value),
    .bus_err(bus_err), .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] v;
    int n = acc_size(f3);
    int base = int'(off) - (int'(off) % n);
    if (n == 4) return w;
    v = (w >> (8 * base)) & ((n == 1) ? 32'hFF : 32'hFFFF);
    if (f3[2] == 1'b0) begin
      if (n == 1 && v >= 32'h80)   v = v | 32'hFFFFFF00;
      if (n == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
    int n = acc_size(f3);
    int base = (n == 4) ? 0 : int'(off) - (int'(off) % n);
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n = acc_size(f3);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [1:0] off);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (int'(off) % acc_size(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one access with the given bus wait cycles and records what the DUT did.
  // swait >= RT means no response is ever given.
  task automatic run_access(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd, input int rwait,
                            input int swait, input logic [31:0] rdata, input bit mis);
    bit last;
    obs_stall_bad = 0; obs_req_cyc = 0; obs_unstable = 0; obs_t0_req = 0; obs_berr_early = 0;
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = !ld; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = data; ex_rd = rd;
    #1;
    if (!stall) obs_stall_bad++;
    if (mem_req_valid) obs_t0_req++;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    ex_addr = $urandom; ex_store_data = $urandom; ex_rd = 5'($urandom);
    if (!mis) begin
      for (int k = 0; k <= rwait; k++) begin
        #1;
        if (!stall) obs_stall_bad++;
        if (mem_req_valid) begin
          if (obs_req_cyc == 0) begin
            obs_addr = mem_req_addr; obs_we = mem_req_we;
            obs_wdata = mem_req_wdata; obs_wstrb = mem_req_wstrb;
          end else if (obs_addr !== mem_req_addr || obs_we !== mem_req_we ||
                       obs_wdata !== mem_req_wdata || obs_wstrb !== mem_req_wstrb) begin
            obs_unstable++;
          end
          obs_req_cyc++;
        end
        if (k == rwait) mem_req_ready = 1'b1;
        step();
      end
      mem_req_ready = 1'b0;
      for (int c = 0; c < RT; c++) begin
        #1;
        if (!stall) obs_stall_bad++;
        if (bus_err) obs_berr_early++;
        last = (c == swait) || (c == RT - 1);
        if (c == swait) begin mem_resp_valid = 1'b1; mem_resp_rdata = rdata; end
        step();
        mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
        if (last) break;
      end
    end
    #1;
    obs_la = wb_load_active; obs_rd = wb_next_rd; obs_val = wb_next_rd_value;
    obs_berr = bus_err; obs_trap = misalign_trap; obs_done_stall = stall;
    if (mem_req_valid) obs_t0_req++;
    step();
    #1;
    obs_after = wb_load_active | bus_err | misalign_trap | stall | mem_req_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b expected 0", mem_req_valid); end
    checks++; if ({mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb} !== '0) begin errors++; $display("FAIL reset_req_fields: got %h/%h/%h expected 0", mem_req_addr, mem_req_wdata, mem_req_wstrb); end
    checks++; if ({wb_load_active, wb_next_rd, wb_next_rd_value} !== '0) begin errors++; $display("FAIL reset_wb: got %0b/%0d/%h expected 0", wb_load_active, wb_next_rd, wb_next_rd_value); end
    checks++; if ({bus_err, misalign_trap} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {bus_err, misalign_trap}); end
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFEF00D;
    step(); step();
    #1;
    checks++; if ({wb_load_active, stall, mem_req_valid, bus_err} !== 4'b0000) begin errors++; $display("FAIL stale_resp_idle: got %b expected 0000", {wb_load_active, stall, mem_req_valid, bus_err}); end
    mem_resp_valid = 1'b0;
    step();
  endtask

  task automatic test_lw_basic();
    run_access(1'b1, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0);
    checks++; if (obs_stall_bad !== 0) begin errors++; $display("FAIL lw_stall_T0_T2: low cycles %0d expected 0", obs_stall_bad); end
    checks++; if (obs_req_cyc !== 1) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 1", obs_req_cyc); end
    checks++; if ({obs_we, obs_addr, obs_wstrb} !== {1'b0, 32'h100, 4'h0}) begin errors++; $display("FAIL lw_req: we %0b addr %h strb %h expected 0/00000100/0", obs_we, obs_addr, obs_wstrb); end
    checks++; if (obs_la !== 1'b1) begin errors++; $display("FAIL lw_load_active_T3: got %0b expected 1", obs_la); end
    checks++; if (obs_rd !== 5'd5) begin errors++; $display("FAIL lw_rd: got %0d expected 5", obs_rd); end
    checks++; if (obs_val !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_value: got %h expected deadbeef", obs_val); end
    checks++; if (obs_done_stall !== 1'b0) begin errors++; $display("FAIL lw_done_stall: got %0b expected 0", obs_done_stall); end
    checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL lw_after_done: got %0b expected 0", obs_after); end
  endtask

  task automatic test_byte_ext();
    run_access(1'b1, 3'b000, 32'h103, 32'h0, 5'd7, 1, 2, 32'h80000000, 1'b0);
    checks++; if (obs_val !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign: got %h expected ffffff80", obs_val); end
    run_access(1'b1, 3'b100, 32'h103, 32'h0, 5'd8, 0, 1, 32'h80000000, 1'b0);
    checks++; if (obs_val !== 32'h00000080) begin errors++; $display("FAIL lbu_zero: got %h expected 00000080", obs_val); end
    checks++; if (obs_rd !== 5'd8 || obs_la !== 1'b1) begin errors++; $display("FAIL lbu_wb: rd %0d active %0b expected 8/1", obs_rd, obs_la); end
  endtask

  task automatic test_sh_delayed();
    run_access(1'b0, 3'b001, 32'h102, 32'h1234ABCD, 5'd3, 3, 1, 32'h0, 1'b0);
    checks++; if (obs_req_cyc !== 4 || obs_unstable !== 0) begin errors++; $display("FAIL sh_req_stable: cycles %0d unstable %0d expected 4/0", obs_req_cyc, obs_unstable); end
    checks++; if (obs_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b expected 1100", obs_wstrb); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", obs_wdata); end
    checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h100) begin errors++; $display("FAIL sh_we_addr: we %0b addr %h expected 1/00000100", obs_we, obs_addr); end
    checks++; if (obs_la !== 1'b0) begin errors++; $display("FAIL sh_no_load_active: got %0b expected 0", obs_la); end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 3'b010, 32'h200, 32'h0, 5'd9, 0, RT + 5, 32'h0, 1'b0);
    checks++; if (obs_berr !== 1'b1 || obs_berr_early !== 0) begin errors++; $display("FAIL timeout_bus_err: done %0b early %0d expected 1/0", obs_berr, obs_berr_early); end
    checks++; if (obs_la !== 1'b0) begin errors++; $display("FAIL timeout_no_load: got %0b expected 0", obs_la); end
    checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL timeout_back_idle: got %0b expected 0", obs_after); end
    run_access(1'b1, 3'b010, 32'h204, 32'h0, 5'd10, 0, RT - 1, 32'h13579BDF, 1'b0);
    checks++; if (obs_berr !== 1'b0 || obs_la !== 1'b1 || obs_val !== 32'h13579BDF) begin errors++; $display("FAIL last_cycle_resp: err %0b active %0b val %h expected 0/1/13579bdf", obs_berr, obs_la, obs_val); end
  endtask

  task automatic test_rd_zero();
    run_access(1'b1, 3'b010, 32'h300, 32'h0, 5'd0, 0, 0, 32'h11111111, 1'b0);
    checks++; if (obs_la !== 1'b0) begin errors++; $display("FAIL rd0_no_active: got %0b expected 0", obs_la); end
  endtask

  task automatic test_reset_mid();
    int berr_seen = 0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h400; ex_rd = 5'd12;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if ({stall, mem_req_valid, wb_load_active, bus_err, misalign_trap} !== 5'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b expected 00000", {stall, mem_req_valid, wb_load_active, bus_err, misalign_trap}); end
    checks++; if ({wb_next_rd, wb_next_rd_value} !== '0) begin errors++; $display("FAIL rst_mid_wb_cleared: rd %0d val %h expected 0", wb_next_rd, wb_next_rd_value); end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55AA55AA;
    step();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < RT + 3; i++) begin
      #1;
      if (bus_err || wb_load_active || stall || mem_req_valid) berr_seen++;
      step();
    end
    checks++; if (berr_seen !== 0) begin errors++; $display("FAIL rst_mid_late_resp: active cycles %0d expected 0", berr_seen); end
    run_access(1'b1, 3'b101, 32'h402, 32'h0, 5'd13, 0, 0, 32'h9ABC1234, 1'b0);
    checks++; if (obs_la !== 1'b1 || obs_val !== 32'h00009ABC) begin errors++; $display("FAIL rst_mid_recover: active %0b val %h expected 1/00009abc", obs_la, obs_val); end
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    run_access(1'b1, 3'b010, 32'h101, 32'h0, 5'd4, 0, 0, 32'h0, 1'b1);
    checks++; if (obs_t0_req !== 0) begin errors++; $display("FAIL mis_no_req: req cycles %0d expected 0", obs_t0_req); end
    checks++; if (obs_trap !== 1'b1 || obs_la !== 1'b0) begin errors++; $display("FAIL mis_trap_T1: trap %0b active %0b expected 1/0", obs_trap, obs_la); end
    checks++; if (obs_after !== 1'b0) begin errors++; $display("FAIL mis_pulse_len: got %0b expected 0", obs_after); end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      bit ld, mis, exp_to, exp_la;
      logic [2:0] f3;
      logic [31:0] addr, data, rdata;
      logic [4:0] rd;
      int rwait, swait, bad;
      ld = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      addr = $urandom; data = $urandom; rdata = $urandom; rd = 5'($urandom_range(0, 31));
      rwait = $urandom_range(0, 3);
      swait = ($urandom_range(0, 5) == 0) ? RT + 2 : $urandom_range(0, 4);
      mis = model_mis(f3, addr[1:0]);
      exp_to = !mis && (swait >= RT);
      exp_la = ld && !mis && !exp_to && (rd != 5'd0);
      run_access(ld, f3, addr, data, rd, rwait, swait, rdata, mis);
      bad = 0;
      if (obs_la !== exp_la) bad++;
      if (obs_berr !== exp_to || obs_berr_early !== 0) bad++;
      if (obs_trap !== mis) bad++;
      if (obs_stall_bad !== 0 || obs_done_stall !== 1'b0 || obs_after !== 1'b0 || obs_t0_req !== 0) bad++;
      if (obs_req_cyc !== (mis ? 0 : rwait + 1) || obs_unstable !== 0) bad++;
      if (!mis && (obs_addr !== {addr[31:2], 2'b00} || obs_we !== !ld)) bad++;
      if (!mis && !ld && (obs_wstrb !== model_strb(f3, addr[1:0]) || obs_wdata !== model_wdata(f3, data))) bad++;
      if (!mis && ld && obs_wstrb !== 4'h0) bad++;
      if (exp_la && (obs_rd !== rd || obs_val !== model_load(f3, addr[1:0], rdata))) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_%0d: ld %0b f3 %b addr %h la %0b/%0b err %0b/%0b val %h/%h strb %h/%h wdata %h/%h (got/expected)",
                 it, ld, f3, addr, obs_la, exp_la, obs_berr, exp_to, obs_val, model_load(f3, addr[1:0], rdata),
                 obs_wstrb, model_strb(f3, addr[1:0]), obs_wdata, model_wdata(f3, data));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_byte_ext();
    test_sh_delayed();
    test_timeout();
    test_rd_zero();
    test_reset_mid();
`ifdef DMEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
